// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the fetch_queue instruction buffer.
// master = fetch/decode side, slave = the queue itself.
interface fetch_queue_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic [WIDTH-1:0]    fetch_valid;
  logic [32*WIDTH-1:0] fetch_instr;
  logic [32*WIDTH-1:0] fetch_pc;
  logic                fetch_ready;
  logic [WIDTH-1:0]    deq_valid;
  logic [32*WIDTH-1:0] deq_instr;
  logic [32*WIDTH-1:0] deq_pc;
  logic [1:0]          deq_accept;
  logic [CNT_W-1:0]    occupancy;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, deq_accept,
    input  fetch_ready, deq_valid, deq_instr, deq_pc, occupancy
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, deq_accept,
    output fetch_ready, deq_valid, deq_instr, deq_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// 3-wide in-order instruction buffer between fetch and decode.
// Compacting enqueue, show-ahead dequeue, full flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fetch_queue_if.slave  fq
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic             enq;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic [PTR_W-1:0] lane_off [WIDTH];

  // Ready looks only at the registered count, so decode never reaches fetch combinationally.
  assign fq.fetch_ready = (count <= CNT_W'(DEPTH - WIDTH));
  assign fq.occupancy   = count;

  // Each valid lane lands at tail + (number of valid lanes older than it).
  always_comb begin
    enq   = fq.fetch_ready && !flush;
    enq_n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_off[i] = enq_n[PTR_W-1:0];
      enq_n       = enq_n + CNT_W'(fq.fetch_valid[i]);
    end
    if (!enq) begin
      enq_n = '0;
    end
    deq_n = (CNT_W'(fq.deq_accept) < count) ? CNT_W'(fq.deq_accept) : count;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
    end
  end

  // Storage carries no reset; validity lives entirely in count/head/tail.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (fq.fetch_valid[i]) begin
          instr_mem[tail + lane_off[i]] <= fq.fetch_instr[32*i +: 32];
          pc_mem[tail + lane_off[i]]    <= fq.fetch_pc[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    fq.deq_valid = '0;
    fq.deq_instr = '0;
    fq.deq_pc    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      fq.deq_valid[i]          = (count > CNT_W'(i));
      fq.deq_instr[32*i +: 32] = instr_mem[head + PTR_W'(i)];
      fq.deq_pc[32*i +: 32]    = pc_mem[head + PTR_W'(i)];
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- 3-wide in-order instruction buffer between instruction fetch and the decode stage.
- Absorbs fetch bursts and decode back-pressure.
- Presents up to three oldest instructions (raw word + PC) per cycle to decode, which builds decode_entry_t records from them.
- Supports a full flush on branch redirect or exception recovery.

Parameters:
- DEPTH, 16, number of instruction slots; power of two, >= 2*WIDTH
- WIDTH, 3, lanes per cycle on both enqueue and dequeue sides; fixed at 3 for this core
- PTR_W, $clog2(DEPTH), head/tail pointer width
- CNT_W, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all queued entries this cycle
- fetch_valid  in  WIDTH  per-lane valid from fetch; lane 0 is oldest
- fetch_instr  in  32*WIDTH  lane i instruction at [32i+31:32i]
- fetch_pc  in  32*WIDTH  lane i PC at [32i+31:32i]
- fetch_ready  out  1  queue can accept a full WIDTH-lane group this cycle
- deq_valid  out  WIDTH  per-lane valid toward decode; thermometer from lane 0
- deq_instr  out  32*WIDTH  head+i instruction on lane i
- deq_pc  out  32*WIDTH  head+i PC on lane i
- deq_accept  in  2  number of head entries decode consumes this cycle (0..3)
- occupancy  out  CNT_W  current number of valid entries

Behaviour:
- Reset (rst=1 at posedge): head=tail=0, count=0, storage contents don't-care.
- Reset outputs (combinational from state): deq_valid=0, occupancy=0, fetch_ready=1.
- rst has priority over flush, enqueue and dequeue.
- fetch_ready = (count <= DEPTH-WIDTH). It depends only on registered count, never on deq_accept, so there is no combinational path from decode to fetch.
- Enqueue fires when fetch_ready=1 and flush=0:
  - Valid lanes are compacted in lane order into tail, tail+1, ...
  - Invalid lanes are skipped; e.g. fetch_valid=3'b101 writes lane0 at tail and lane2 at tail+1.
  - tail advances by popcount(fetch_valid).
- When fetch_ready=0, fetch inputs are ignored. Fetch must hold its group.
- Dequeue is show-ahead:
  - Lane i shows entry (head+i) mod DEPTH.
  - deq_valid[i] = (count > i).
  - Data on lanes with deq_valid=0 is don't-care.
- deq_accept:
  - Effective consume = min(deq_accept, count); an over-request is clamped, never underflows.
  - head advances by the effective consume at the posedge.
  - Decode accepts only a prefix (oldest first), so program order is preserved.
- Simultaneous enqueue and dequeue in the same cycle: count_next = count + enq_n - deq_n.
  - Enqueue write slots are computed from the current tail and never collide with entries being read.
  - The fetch_ready rule guarantees no overflow.
- Pointer arithmetic is mod DEPTH, using natural PTR_W wrap; a 3-entry write or read straddling slot DEPTH-1 -> 0 must work.
- flush=1 (and rst=0):
  - At the posedge: head=tail=0, count=0.
  - Same-cycle enqueue and deq_accept are ignored; nothing from that cycle survives.
  - deq_valid during the flush cycle still reflects the pre-flush state; decode is responsible for squashing.
- Latency: an instruction enqueued at posedge N is visible on deq_* in cycle N+1 (1-cycle minimum fetch-to-decode residency). There is no bypass when empty.
- occupancy = count, registered, range 0..DEPTH.
- Storage has no reset requirement; valid tracking is solely via count and pointers.

Test Plan:
- Reset then idle: assert rst 2 cycles, release -> deq_valid=000, occupancy=0, fetch_ready=1; no X on control outputs.
- Single group, then drain:
  - Enqueue PCs 0x100/0x104/0x108 with fetch_valid=111 -> next cycle deq_valid=111 with those PCs in lane order.
  - deq_accept=2 -> following cycle lane0 PC=0x108, deq_valid=001.
- Fill and back-pressure (DEPTH=16):
  - Enqueue 111 every cycle with deq_accept=0 -> occupancy 3,6,9,12,15 and fetch_ready=0 at 15.
  - Held group not written; deq_accept=3 once -> occupancy=12, fetch_ready=1.
- Sparse lanes plus over-accept:
  - fetch_valid=101 with PCs A,B,C -> queue holds A,C only (occupancy=2).
  - deq_accept=3 -> clamped to 2; occupancy=0, no underflow.
- Wrap-around with simultaneous ops:
  - Steady state enqueue 111 and deq_accept=3 for 10 cycles -> pointers wrap past 15.
  - PC sequence on deq lanes is continuous +4 with no gaps; occupancy constant.
- Flush mid-stream:
  - With occupancy=9, assert flush together with fetch_valid=111 and deq_accept=3 -> next cycle occupancy=0, deq_valid=000.
  - Next enqueued group appears at lane0 with correct PC.
  - Repeat with rst and flush asserted together -> reset state.
